// File: rtl/axi_pkg.sv
// ---- axi_pkg : shared encodings for the AXI read-slave FSM and burst address generator | rev 1.0 ----
`default_nettype none
package axi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_LOAD = 2'd2,
    ST_DATA = 2'd3
  } state_t;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // WRAP needs a power-of-two beat count so the wrap window is aligned.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_burst_addr_gen.sv
// ---- axi_burst_addr_gen : combinational next beat address for FIXED/INCR/WRAP bursts | rev 1.0 ----
`default_nettype none
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic [AW-1:0] addr,
  input  logic [2:0]    size,
  input  logic [7:0]    len,
  input  logic [1:0]    burst,
  output logic [AW-1:0] next_addr
);

  logic [AW-1:0] bytes;
  logic [AW-1:0] total;
  logic [AW-1:0] base;
  logic [AW-1:0] incr_addr;

  always_comb begin
    bytes     = AW'(1) << size;
    total     = bytes * (AW'(len) + AW'(1));
    base      = addr & ~(total - AW'(1));
    incr_addr = (addr & ~(bytes - AW'(1))) + bytes;
    next_addr = incr_addr;
    // Reserved burst codes and odd WRAP lengths fall through to INCR.
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP: begin
        if (wrap_len_ok(len)) begin
          next_addr = base + ((addr + bytes - base) & (total - AW'(1)));
        end
      end
      default: next_addr = incr_addr;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/axi_rd_slave_fsm.sv
// ---- axi_rd_slave_fsm : AXI read responder over a 1-cycle-latency memory port | rev 1.0 ----
// ---- optional burst legality checking with SLVERR responses: define AXI_RD_ERR_CHK_EN ----
`default_nettype none
module axi_rd_slave_fsm
  import axi_pkg::*;
#(
  parameter int IDW = 12,
  parameter int AW  = 32,
  parameter int DW  = 64
) (
  input  logic           axi_aclk,
  input  logic           axi_aresetn,
  input  logic [IDW-1:0] axi_arid,
  input  logic [AW-1:0]  axi_araddr,
  input  logic [7:0]     axi_arlen,
  input  logic [2:0]     axi_arsize,
  input  logic [1:0]     axi_arburst,
  input  logic           axi_arvalid,
  output logic           axi_arready,
  output logic [IDW-1:0] axi_rid,
  output logic [DW-1:0]  axi_rdata,
  output logic [1:0]     axi_rresp,
  output logic           axi_rlast,
  output logic           axi_rvalid,
  input  logic           axi_rready,
  output logic           mem_ren,
  output logic [AW-1:0]  mem_raddr,
  input  logic [DW-1:0]  mem_rdata
);

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] next_addr;
  logic [7:0]    len_q;
  logic [7:0]    cnt_q;
  logic [2:0]    size_q;
  logic [1:0]    burst_q;
  logic          err_q;
  logic          ar_hs;
  logic          ar_err;

  assign ar_hs = axi_arvalid && axi_arready;

`ifdef AXI_RD_ERR_CHK_EN
  assign ar_err = (axi_arburst == BURST_RSVD)
               || ((axi_arburst == BURST_WRAP) && !wrap_len_ok(axi_arlen))
               || ((32'd1 << axi_arsize) > 32'(DW / 8));
`else
  assign ar_err = 1'b0;
`endif

  axi_burst_addr_gen #(.AW(AW)) u_addr_gen (
    .addr      (addr_q),
    .size      (size_q),
    .len       (len_q),
    .burst     (burst_q),
    .next_addr (next_addr)
  );

  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (ar_hs) state_nxt = ST_READ;
      ST_READ: state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = ST_DATA;
      ST_DATA: if (axi_rready) state_nxt = axi_rlast ? ST_IDLE : ST_READ;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    axi_arready = (state == ST_IDLE);
    axi_rvalid  = (state == ST_DATA);
    mem_ren     = (state == ST_READ) && !err_q;
    mem_raddr   = addr_q;
  end

  // Burst context and the registered R channel payload.
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      err_q     <= 1'b0;
      axi_rid   <= '0;
      axi_rdata <= '0;
      axi_rresp <= RESP_OKAY;
      axi_rlast <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ar_hs) begin
            addr_q  <= axi_araddr;
            len_q   <= axi_arlen;
            cnt_q   <= axi_arlen;
            size_q  <= axi_arsize;
            burst_q <= axi_arburst;
            err_q   <= ar_err;
            axi_rid <= axi_arid;
          end
        end
        ST_LOAD: begin
          axi_rdata <= err_q ? '0 : mem_rdata;
          axi_rresp <= err_q ? RESP_SLVERR : RESP_OKAY;
          axi_rlast <= (cnt_q == 8'd0);
        end
        ST_DATA: begin
          if (axi_rready) begin
            if (axi_rlast) begin
              axi_rlast <= 1'b0;
            end else begin
              cnt_q  <= cnt_q - 8'd1;
              addr_q <= next_addr;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_slave_fsm.sv
// ---- tb_axi_rd_slave_fsm : scoreboard bench for axi_rd_slave_fsm | rev 1.0 ----
`default_nettype none
module tb_axi_rd_slave_fsm;

  localparam int IDW = 12;
  localparam int AW  = 32;
  localparam int DW  = 64;

  logic           clk = 1'b0;
  logic           aresetn;
  logic [IDW-1:0] arid;
  logic [AW-1:0]  araddr;
  logic [7:0]     arlen;
  logic [2:0]     arsize;
  logic [1:0]     arburst;
  logic           arvalid;
  logic           arready;
  logic [IDW-1:0] rid;
  logic [DW-1:0]  rdata;
  logic [1:0]     rresp;
  logic           rlast;
  logic           rvalid;
  logic           rready;
  logic           mem_ren;
  logic [AW-1:0]  mem_raddr;
  logic [DW-1:0]  mem_rdata = '0;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [DW-1:0]  data;
    logic [1:0]     resp;
    logic           last;
  } beat_t;

  beat_t         exp_beat_q[$];
  logic [AW-1:0] exp_addr_q[$];
  logic [AW-1:0] addr_log[$];
  int            checks = 0;
  int            errors = 0;
  int            beats_seen = 0;

  always #5 clk = ~clk;

  axi_rd_slave_fsm #(.IDW(IDW), .AW(AW), .DW(DW)) dut (
    .axi_aclk    (clk),
    .axi_aresetn (aresetn),
    .axi_arid    (arid),
    .axi_araddr  (araddr),
    .axi_arlen   (arlen),
    .axi_arsize  (arsize),
    .axi_arburst (arburst),
    .axi_arvalid (arvalid),
    .axi_arready (arready),
    .axi_rid     (rid),
    .axi_rdata   (rdata),
    .axi_rresp   (rresp),
    .axi_rlast   (rlast),
    .axi_rvalid  (rvalid),
    .axi_rready  (rready),
    .mem_ren     (mem_ren),
    .mem_raddr   (mem_raddr),
    .mem_rdata   (mem_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {~a, a};
  endfunction

  function automatic logic is_pow2_len(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

  function automatic logic [AW-1:0] model_next(input logic [AW-1:0] a, input logic [2:0] size,
                                               input logic [7:0] len, input logic [1:0] burst);
    logic [AW-1:0] bytes;
    logic [AW-1:0] total;
    logic [AW-1:0] base;
    bytes = AW'(1) << size;
    if (burst == 2'b00) return a;
    if (burst == 2'b10 && is_pow2_len(len)) begin
      total = bytes * (AW'(len) + AW'(1));
      base  = a - (a % total);
      return base + ((a + bytes - base) % total);
    end
    return a - (a % bytes) + bytes;
  endfunction

  function automatic logic is_illegal(input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
`ifdef AXI_RD_ERR_CHK_EN
    return (burst == 2'b11) || (burst == 2'b10 && !is_pow2_len(len)) || ((1 << size) > DW / 8);
`else
    return 1'b0;
`endif
  endfunction

  task automatic push_exp(input logic [IDW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    logic [AW-1:0] a;
    logic          ill;
    beat_t         b;
    a   = addr;
    ill = is_illegal(len, size, burst);
    for (int i = 0; i <= int'(len); i++) begin
      if (!ill) exp_addr_q.push_back(a);
      b.id   = id;
      b.data = ill ? '0 : mem_word(a);
      b.resp = ill ? 2'b10 : 2'b00;
      b.last = (i == int'(len));
      exp_beat_q.push_back(b);
      a = model_next(a, size, len, burst);
    end
  endtask

  always @(posedge clk) begin
    if (mem_ren) mem_rdata <= mem_word(mem_raddr);
  end

  always @(negedge clk) begin
    if (aresetn) begin
      if (mem_ren) begin
        addr_log.push_back(mem_raddr);
        if (exp_addr_q.size() == 0) chk("unexpected_mem_ren", 64'(mem_raddr), 64'hFFFF_FFFF_FFFF_FFFF);
        else chk("mem_raddr", 64'(mem_raddr), 64'(exp_addr_q.pop_front()));
      end
      if (rvalid && rready) begin
        beats_seen++;
        if (exp_beat_q.size() == 0) begin
          chk("unexpected_beat", 64'(rid), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          beat_t e;
          e = exp_beat_q.pop_front();
          chk("rid", 64'(rid), 64'(e.id));
          chk("rdata", rdata, e.data);
          chk("rresp", 64'(rresp), 64'(e.resp));
          chk("rlast", 64'(rlast), 64'(e.last));
        end
      end
    end
  end

  task automatic send_ar(input logic [IDW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    logic got;
    got = 1'b0;
    @(posedge clk); #1;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (arready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("ar_timeout", 64'(0), 64'(1));
    else push_exp(id, addr, len, size, burst);
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (exp_beat_q.size() == 0 && arready) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk("idle_timeout", 64'(0), 64'(1));
    chk("addr_q_left", 64'(exp_addr_q.size()), 64'(0));
  endtask

  task automatic wait_beats(input int n);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (beats_seen >= n) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk("beat_timeout", 64'(beats_seen), 64'(n));
  endtask

  task automatic wait_rvalid();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rvalid) begin
        done = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!done) chk("rvalid_timeout", 64'(0), 64'(1));
  endtask

  task automatic chk_log(input string tag, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [AW-1:0] a2, input logic [AW-1:0] a3);
    logic [AW-1:0] exp[4];
    exp = '{a0, a1, a2, a3};
    chk({tag, "_len"}, 64'(addr_log.size()), 64'(4));
    for (int i = 0; i < 4 && i < addr_log.size(); i++) chk(tag, 64'(addr_log[i]), 64'(exp[i]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0]  h_data;
    logic [AW-1:0]  h_addr;
    logic           h_last;
    int             base;

    aresetn = 1'b0; arvalid = 1'b0; rready = 1'b1;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_arready", 64'(arready), 64'(1));
    chk("rst_rvalid", 64'(rvalid), 64'(0));
    chk("rst_rlast", 64'(rlast), 64'(0));
    chk("rst_rid", 64'(rid), 64'(0));
    chk("rst_rdata", rdata, 64'(0));
    chk("rst_rresp", 64'(rresp), 64'(0));
    chk("rst_mem_ren", 64'(mem_ren), 64'(0));
    @(posedge clk); #1;
    aresetn = 1'b1;

    // Single beat: latency cycle 1 for mem_ren, cycle 3 for rvalid.
    send_ar(12'd5, 32'h100, 8'd0, 3'd3, 2'b01);
    @(negedge clk);
    chk("lat_mem_ren_c1", 64'(mem_ren), 64'(1));
    chk("lat_mem_raddr_c1", 64'(mem_raddr), 64'h100);
    @(negedge clk);
    chk("lat_rvalid_c2", 64'(rvalid), 64'(0));
    chk("lat_arready_c2", 64'(arready), 64'(0));
    @(negedge clk);
    chk("lat_rvalid_c3", 64'(rvalid), 64'(1));
    chk("lat_rlast_c3", 64'(rlast), 64'(1));
    @(negedge clk);
    chk("arready_after_r", 64'(arready), 64'(1));
    wait_idle();

    addr_log.delete();
    send_ar(12'd6, 32'h104, 8'd3, 3'd3, 2'b01);
    wait_idle();
    chk_log("incr_addr", 32'h104, 32'h108, 32'h110, 32'h118);

    addr_log.delete();
    send_ar(12'd7, 32'h118, 8'd3, 3'd3, 2'b10);
    wait_idle();
    chk_log("wrap_addr", 32'h118, 32'h100, 32'h108, 32'h110);

    send_ar(12'd8, 32'h20, 8'd2, 3'd2, 2'b00);
    wait_idle();
    send_ar(12'h3A5, 32'h3C, 8'd7, 3'd2, 2'b10);
    wait_idle();

    // Backpressure on beat 2.
    base = beats_seen;
    send_ar(12'd9, 32'h200, 8'd3, 3'd3, 2'b01);
    wait_beats(base + 1);
    rready = 1'b0;
    wait_rvalid();
    h_data = rdata; h_last = rlast; h_addr = mem_raddr;
    repeat (5) begin
      @(negedge clk);
      chk("stall_rvalid", 64'(rvalid), 64'(1));
      chk("stall_rdata", rdata, h_data);
      chk("stall_rlast", 64'(rlast), 64'(h_last));
      chk("stall_mem_ren", 64'(mem_ren), 64'(0));
      chk("stall_raddr", 64'(mem_raddr), 64'(h_addr));
    end
    @(posedge clk); #1;
    rready = 1'b1;
    wait_idle();

    // Reset during beat 2 of 8.
    base = beats_seen;
    send_ar(12'd10, 32'h300, 8'd7, 3'd3, 2'b01);
    wait_beats(base + 1);
    wait_rvalid();
    aresetn = 1'b0;
    exp_beat_q.delete();
    exp_addr_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("midrst_rvalid", 64'(rvalid), 64'(0));
    chk("midrst_arready", 64'(arready), 64'(1));
    @(posedge clk); #1;
    aresetn = 1'b1;
    send_ar(12'd11, 32'h40, 8'd1, 3'd2, 2'b01);
    wait_idle();

    // Reserved burst, odd WRAP length and oversize beats.
    send_ar(12'd12, 32'h80, 8'd2, 3'd3, 2'b11);
    wait_idle();
    send_ar(12'd13, 32'h88, 8'd2, 3'd3, 2'b10);
    wait_idle();
    send_ar(12'd14, 32'h400, 8'd1, 3'd4, 2'b01);
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
